// File: rtl/flags_pkg.sv
// Shared definitions for the EFLAGS update path: flag bit positions, source masks, the bit-op
// encoding, the interrupt-entry state encoding and the merge-source select.
package flags_pkg;

   localparam int unsigned CfBit   = 0;
   localparam int unsigned PfBit   = 2;
   localparam int unsigned AfBit   = 4;
   localparam int unsigned ZfBit   = 6;
   localparam int unsigned SfBit   = 7;
   localparam int unsigned TfBit   = 8;
   localparam int unsigned IfBit   = 9;
   localparam int unsigned DfBit   = 10;
   localparam int unsigned OfBit   = 11;
   localparam int unsigned IoplLo  = 12;
   localparam int unsigned IoplHi  = 13;
   localparam int unsigned NtBit   = 14;
   localparam int unsigned RfBit   = 16;
   localparam int unsigned VmBit   = 17;

   localparam logic [31:0] WritableMask = 32'h0003_7FD5;
   localparam logic [31:0] ForceOne     = 32'h0000_0002;
   localparam logic [31:0] AluMask      = 32'h0000_08D5;
   // Flags dropped from the image on interrupt entry (IF handled separately by the gate bit).
   localparam logic [31:0] IntClearMask = (32'd1 << TfBit) | (32'd1 << NtBit) |
                                          (32'd1 << RfBit) | (32'd1 << VmBit);

   typedef enum logic [2:0] {
      BitClc = 3'd0,
      BitStc = 3'd1,
      BitCmc = 3'd2,
      BitCld = 3'd3,
      BitStd = 3'd4,
      BitCli = 3'd5,
      BitSti = 3'd6
   } bit_op_e;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIntSave  = 2'd1,
      StIntClear = 2'd2
   } int_state_e;

   typedef enum logic [1:0] {
      SrcAlu = 2'd0,
      SrcPop = 2'd1,
      SrcBit = 2'd2
   } src_e;

endpackage

// File: rtl/flags_merge.sv
// Combinational image builder: picks the per-source mask and source bits, applies the privilege
// rules against the IOPL found in the merge base, and forms the reserved-bit-forced image.
//  src_i            source select (src_e)
//  base_i           merge base (in-flight write or current EFLAGS)
//  alu_*/pop_*/bit_op_i  per-source operands
//  protected_mode_i, cpl_i  privilege context
//  image_o          new EFLAGS image
//  priv_fault_o     CLI/STI refused at the current privilege level
module flags_merge
   import flags_pkg::*;
(
   input  logic [1:0]  src_i,
   input  logic [31:0] base_i,
   input  logic [31:0] alu_flags_i,
   input  logic [31:0] alu_mask_i,
   input  logic [31:0] pop_data_i,
   input  logic        pop_is_iret_i,
   input  logic [2:0]  bit_op_i,
   input  logic        protected_mode_i,
   input  logic [1:0]  cpl_i,
   output logic [31:0] image_o,
   output logic        priv_fault_o
);

   logic [31:0] mask;
   logic [31:0] src;
   logic [1:0]  iopl;
   logic        cpl_above_iopl;

   always_comb begin
      mask           = '0;
      src            = '0;
      priv_fault_o   = 1'b0;
      iopl           = base_i[IoplHi:IoplLo];
      cpl_above_iopl = protected_mode_i && (cpl_i > iopl);

      case (src_i)
         SrcAlu: begin
            mask = alu_mask_i & AluMask;
            src  = alu_flags_i;
         end
         SrcPop: begin
            src  = pop_data_i;
            mask = WritableMask & ~((32'd1 << VmBit) | (32'd1 << RfBit));
            if (protected_mode_i && (cpl_i != 2'd0)) begin
               mask[IoplHi:IoplLo] = 2'b00;
            end
            if (cpl_above_iopl) begin
               mask[IfBit] = 1'b0;
            end
            if (pop_is_iret_i) begin
               mask[RfBit] = 1'b1;
               if (protected_mode_i && (cpl_i == 2'd0)) begin
                  mask[VmBit] = 1'b1;
               end
            end
         end
         SrcBit: begin
            case (bit_op_e'(bit_op_i))
               BitClc: mask[CfBit] = 1'b1;
               BitStc: begin
                  mask[CfBit] = 1'b1;
                  src[CfBit]  = 1'b1;
               end
               BitCmc: begin
                  mask[CfBit] = 1'b1;
                  src[CfBit]  = ~base_i[CfBit];
               end
               BitCld: mask[DfBit] = 1'b1;
               BitStd: begin
                  mask[DfBit] = 1'b1;
                  src[DfBit]  = 1'b1;
               end
               BitCli, BitSti: begin
                  mask[IfBit]  = 1'b1;
                  src[IfBit]   = (bit_op_i == BitSti);
                  priv_fault_o = cpl_above_iopl;
               end
               default: ;
            endcase
         end
         default: ;
      endcase

      image_o = (((base_i & ~mask) | (src & mask)) & WritableMask) | ForceOne;
   end

endmodule

// File: rtl/flags_update_controller.sv
// Single write master for EFLAGS. Grants one of interrupt entry, POPF/IRET, bit op or ALU update
// per cycle (in that priority, only when idle), registers the merged image towards flags_register
// and sequences the interrupt-entry save/clear.
//  clock, reset        clock and synchronous active-high reset
//  eflags              current EFLAGS; protected_mode/cpl privilege context
//  alu_*, pop_*, bit_*, int_*   request/operand/ack groups (acks are combinational grants)
//  saved_flags/valid/ack        image to push on interrupt entry
//  flags_we, flags_wdata        registered write port to flags_register
//  busy                         interrupt sequence in progress
module flags_update_controller
   import flags_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] eflags,
   input  logic        protected_mode,
   input  logic [1:0]  cpl,
   input  logic        alu_req,
   input  logic [31:0] alu_flags,
   input  logic [31:0] alu_mask,
   output logic        alu_ack,
   input  logic        pop_req,
   input  logic [31:0] pop_data,
   input  logic        pop_is_iret,
   output logic        pop_ack,
   input  logic        bit_req,
   input  logic [2:0]  bit_op,
   output logic        bit_ack,
   output logic        bit_fault,
   input  logic        int_req,
   input  logic        int_gate,
   output logic        int_ack,
   output logic [31:0] saved_flags,
   output logic        saved_valid,
   input  logic        saved_ack,
   output logic        flags_we,
   output logic [31:0] flags_wdata,
   output logic        busy
);

   int_state_e  state_q, state_d;
   logic        flags_we_q, flags_we_d;
   logic [31:0] flags_wdata_q, flags_wdata_d;
   logic [31:0] saved_flags_q, saved_flags_d;
   logic        saved_valid_q, saved_valid_d;
   logic        gate_q, gate_d;

   logic [31:0] base;
   logic [1:0]  src_sel;
   logic [31:0] image;
   logic        priv_fault;

   // A write issued last cycle has not reached flags_register yet; merge on top of it.
   assign base    = flags_we_q ? flags_wdata_q : eflags;
   assign src_sel = pop_req ? SrcPop : (bit_req ? SrcBit : SrcAlu);

   flags_merge u_merge (
      .src_i            (src_sel),
      .base_i           (base),
      .alu_flags_i      (alu_flags),
      .alu_mask_i       (alu_mask),
      .pop_data_i       (pop_data),
      .pop_is_iret_i    (pop_is_iret),
      .bit_op_i         (bit_op),
      .protected_mode_i (protected_mode),
      .cpl_i            (cpl),
      .image_o          (image),
      .priv_fault_o     (priv_fault)
   );

   always_comb begin
      state_d       = state_q;
      flags_we_d    = 1'b0;
      flags_wdata_d = flags_wdata_q;
      saved_flags_d = saved_flags_q;
      saved_valid_d = saved_valid_q;
      gate_d        = gate_q;
      int_ack       = 1'b0;
      pop_ack       = 1'b0;
      bit_ack       = 1'b0;
      bit_fault     = 1'b0;
      alu_ack       = 1'b0;

      case (state_q)
         StIdle: begin
            if (int_req) begin
               int_ack       = 1'b1;
               saved_flags_d = base;
               saved_valid_d = 1'b1;
               gate_d        = int_gate;
               state_d       = StIntSave;
            end else if (pop_req) begin
               pop_ack       = 1'b1;
               flags_we_d    = 1'b1;
               flags_wdata_d = image;
            end else if (bit_req) begin
               bit_ack = 1'b1;
               if (priv_fault) begin
                  bit_fault = 1'b1;
               end else begin
                  flags_we_d    = 1'b1;
                  flags_wdata_d = image;
               end
            end else if (alu_req) begin
               alu_ack       = 1'b1;
               flags_we_d    = 1'b1;
               flags_wdata_d = image;
            end
         end
         StIntSave: begin
            if (saved_ack) begin
               saved_valid_d = 1'b0;
               state_d       = StIntClear;
            end
         end
         StIntClear: begin
            flags_we_d    = 1'b1;
            flags_wdata_d = (saved_flags_q & ~IntClearMask &
                             ~(gate_q ? (32'd1 << IfBit) : 32'd0)) | ForceOne;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         flags_we_q    <= 1'b0;
         flags_wdata_q <= '0;
         saved_flags_q <= '0;
         saved_valid_q <= 1'b0;
         gate_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         flags_we_q    <= flags_we_d;
         flags_wdata_q <= flags_wdata_d;
         saved_flags_q <= saved_flags_d;
         saved_valid_q <= saved_valid_d;
         gate_q        <= gate_d;
      end
   end

   assign flags_we    = flags_we_q;
   assign flags_wdata = flags_wdata_q;
   assign saved_flags = saved_flags_q;
   assign saved_valid = saved_valid_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_flags_update_controller.sv
// Randomized bench for flags_update_controller with a flag-rule reference model.
module tb_flags_update_controller;

   localparam logic [31:0] WR    = 32'h0003_7FD5;
   localparam logic [31:0] ALU_M = 32'h0000_08D5;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] eflags;
   logic        protected_mode;
   logic [1:0]  cpl;
   logic        alu_req, pop_req, bit_req, int_req;
   logic [31:0] alu_flags, alu_mask, pop_data;
   logic        pop_is_iret, int_gate, saved_ack;
   logic [2:0]  bit_op;
   logic        alu_ack, pop_ack, bit_ack, bit_fault, int_ack;
   logic [31:0] saved_flags, flags_wdata;
   logic        saved_valid, flags_we, busy;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the pending write as seen by flags_register.
   logic        m_we = 1'b0;
   logic [31:0] m_wdata = '0;

   always #5 clock = ~clock;

   flags_update_controller dut (
      .clock(clock), .reset(reset), .eflags(eflags), .protected_mode(protected_mode), .cpl(cpl),
      .alu_req(alu_req), .alu_flags(alu_flags), .alu_mask(alu_mask), .alu_ack(alu_ack),
      .pop_req(pop_req), .pop_data(pop_data), .pop_is_iret(pop_is_iret), .pop_ack(pop_ack),
      .bit_req(bit_req), .bit_op(bit_op), .bit_ack(bit_ack), .bit_fault(bit_fault),
      .int_req(int_req), .int_gate(int_gate), .int_ack(int_ack),
      .saved_flags(saved_flags), .saved_valid(saved_valid), .saved_ack(saved_ack),
      .flags_we(flags_we), .flags_wdata(flags_wdata), .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_reqs();
      alu_req = 0; pop_req = 0; bit_req = 0; int_req = 0; saved_ack = 0;
   endtask

   // Unchanged flags keep their base value (reserved bits dropped, bit 1 forced).
   function automatic logic [31:0] keep(input logic [31:0] base);
      return (base & WR) | 32'h2;
   endfunction

   function automatic logic [31:0] exp_alu(input logic [31:0] base, input logic [31:0] f,
                                           input logic [31:0] m);
      logic [31:0] r;
      r = keep(base);
      for (int i = 0; i < 32; i++) if (ALU_M[i] && m[i]) r[i] = f[i];
      return r;
   endfunction

   function automatic logic [31:0] exp_pop(input logic [31:0] base, input logic [31:0] d,
                                           input logic iret, input logic pm, input logic [1:0] pl);
      logic [31:0] ok;
      logic [31:0] r;
      ok = WR;
      ok[16] = iret;
      ok[17] = iret && pm && (pl == 0);
      if (pm && pl != 0) begin ok[12] = 0; ok[13] = 0; end
      if (pm && pl > base[13:12]) ok[9] = 0;
      r = keep(base);
      for (int i = 0; i < 32; i++) if (ok[i]) r[i] = d[i];
      return r;
   endfunction

   function automatic void exp_bit(input logic [31:0] base, input logic [2:0] op, input logic pm,
                                   input logic [1:0] pl, output logic [31:0] r,
                                   output logic flt);
      r   = keep(base);
      flt = 0;
      case (op)
         3'd0: r[0] = 0;
         3'd1: r[0] = 1;
         3'd2: r[0] = ~base[0];
         3'd3: r[10] = 0;
         3'd4: r[10] = 1;
         3'd5, 3'd6: begin
            if (pm && pl > base[13:12]) flt = 1;
            else r[9] = (op == 3'd6);
         end
         default: ;
      endcase
   endfunction

   // One idle-state cycle with inputs already driven: check grant, advance model, check write.
   task automatic run_cycle();
      logic [31:0] base, img, bimg;
      logic ep, eb, ea, ef, bf, nwe;
      #1;
      base = m_we ? m_wdata : eflags;
      {ep, eb, ea, ef, nwe} = '0;
      img = m_wdata;
      if (pop_req) begin
         ep = 1; nwe = 1; img = exp_pop(base, pop_data, pop_is_iret, protected_mode, cpl);
      end else if (bit_req) begin
         eb = 1;
         exp_bit(base, bit_op, protected_mode, cpl, bimg, bf);
         ef = bf;
         if (!bf) begin nwe = 1; img = bimg; end
      end else if (alu_req) begin
         ea = 1; nwe = 1; img = exp_alu(base, alu_flags, alu_mask);
      end
      check_eq("acks", {int_ack, pop_ack, bit_ack, alu_ack, bit_fault}, {1'b0, ep, eb, ea, ef});
      check_eq("busy_idle", busy, 0);
      m_we = nwe;
      if (nwe) m_wdata = img;
      tick();
      check_eq("flags_we", flags_we, m_we);
      if (m_we) check_eq("flags_wdata", flags_wdata, m_wdata);
   endtask

   task automatic rand_cycle();
      eflags = $urandom; protected_mode = 1'($urandom); cpl = 2'($urandom);
      int_req = 0; saved_ack = 1'($urandom);
      alu_req = 1'($urandom); pop_req = 1'($urandom_range(0, 3) == 0); bit_req = 1'($urandom);
      alu_flags = $urandom; alu_mask = $urandom; pop_data = $urandom;
      pop_is_iret = 1'($urandom); bit_op = 3'($urandom);
      run_cycle();
   endtask

   task automatic do_int(input logic [31:0] ef_val, input logic gate, input int delay,
                         input logic alu_too);
      logic [31:0] exp_saved, exp_clr;
      clear_reqs();
      eflags = ef_val; int_req = 1; int_gate = gate; alu_req = alu_too; saved_ack = 1;
      alu_flags = $urandom; alu_mask = $urandom;
      #1;
      check_eq("int_grant", {int_ack, pop_ack, bit_ack, alu_ack, bit_fault}, 5'b10000);
      exp_saved = m_we ? m_wdata : eflags;
      m_we = 0;
      tick();
      int_req = 0; saved_ack = 0; int_gate = ~gate; eflags = $urandom;
      check_eq("int_we0", flags_we, 0);
      for (int i = 0; i < delay; i++) begin
         check_eq("save_busy", busy, 1);
         check_eq("save_valid", saved_valid, 1);
         check_eq("saved_flags", saved_flags, exp_saved);
         check_eq("save_alu_wait", alu_ack, 0);
         tick();
         check_eq("save_we", flags_we, 0);
      end
      saved_ack = 1;
      #1;
      check_eq("save_valid_last", saved_valid, 1);
      check_eq("save_alu_wait2", alu_ack, 0);
      tick();
      check_eq("clear_busy", busy, 1);
      check_eq("clear_valid", saved_valid, 0);
      check_eq("clear_alu_wait", alu_ack, 0);
      saved_ack = 0;
      tick();
      exp_clr = exp_saved;
      exp_clr[8] = 0; exp_clr[14] = 0; exp_clr[16] = 0; exp_clr[17] = 0;
      if (gate) exp_clr[9] = 0;
      exp_clr[1] = 1;
      check_eq("int_we", flags_we, 1);
      check_eq("int_wdata", flags_wdata, exp_clr);
      check_eq("int_busy_done", busy, 0);
      m_we = 1; m_wdata = exp_clr;
      if (!alu_too) clear_reqs();
      run_cycle();
      clear_reqs();
   endtask

   initial begin
      reset = 1; clear_reqs();
      eflags = 32'h2; protected_mode = 0; cpl = 0; alu_flags = 0; alu_mask = 0;
      pop_data = 0; pop_is_iret = 0; bit_op = 0; int_gate = 0;
      repeat (3) tick();
      check_eq("rst_we", flags_we, 0);
      check_eq("rst_wdata", flags_wdata, 0);
      check_eq("rst_saved", saved_flags, 0);
      check_eq("rst_valid", saved_valid, 0);
      check_eq("rst_busy", busy, 0);
      reset = 0;
      #1;
      check_eq("rst_acks", {int_ack, pop_ack, bit_ack, alu_ack, bit_fault}, 0);
      tick();

      // 1: reset in the middle of INT_SAVE
      int_req = 1; eflags = 32'h0302; tick();
      int_req = 0; tick();
      check_eq("t1_busy_pre", busy, 1);
      reset = 1; tick(); tick(); reset = 0;
      check_eq("t1_busy", busy, 0);
      check_eq("t1_valid", saved_valid, 0);
      check_eq("t1_saved", saved_flags, 0);
      m_we = 0;
      tick();
      check_eq("t1_we", flags_we, 0);

      // 2: ALU update
      clear_reqs(); eflags = 32'h2; alu_req = 1; alu_flags = 32'h8C1; alu_mask = 32'h8D5;
      run_cycle();
      check_eq("t2_wdata", flags_wdata, 32'h8C3);
      clear_reqs(); run_cycle();

      // 3: POPF with privilege masking, then at cpl 0
      eflags = 32'h2; protected_mode = 1; cpl = 3; pop_req = 1; pop_data = 32'h3202;
      pop_is_iret = 0;
      run_cycle();
      check_eq("t3_cpl3", flags_wdata, 32'h2);
      clear_reqs(); run_cycle();
      eflags = 32'h2; cpl = 0; pop_req = 1;
      run_cycle();
      check_eq("t3_cpl0", flags_wdata, 32'h3202);
      clear_reqs(); run_cycle();

      // 4: CLI refused
      eflags = 32'h0202; cpl = 3; bit_req = 1; bit_op = 3'd5;
      run_cycle();
      check_eq("t4_fault_nowrite", flags_we, 0);
      clear_reqs(); run_cycle();

      // 5: interrupt entry with gate, ALU waiting
      do_int(32'h0302, 1'b1, 3, 1'b1);
      run_cycle();

      // 6: ALU then STC back-to-back, eflags stale
      eflags = 32'h2; alu_req = 1; alu_flags = 32'h8C0; alu_mask = 32'h8D5;
      run_cycle();
      alu_req = 0; bit_req = 1; bit_op = 3'd1; eflags = 32'h2;
      run_cycle();
      check_eq("t6_wdata", flags_wdata, 32'h8C3);
      clear_reqs(); run_cycle();

      // Random traffic with occasional interrupt entries
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 19) == 0)
            do_int($urandom, 1'($urandom), $urandom_range(0, 4), 1'($urandom));
         else
            rand_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
